// File: rtl/angle_entry.sv
// rtl/angle_entry.sv - button-driven angle editor with valid/ready output to the trig core
// Synchronizes four debounced buttons, edits a wrapping angle, and submits it on enter.
module angle_entry #(
  parameter int ANGLE_W     = 9,
  parameter int ANGLE_MAX   = 359,
  parameter int STEP_FINE   = 1,
  parameter int STEP_COARSE = 10
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_dn,
  input  logic               btn_mode,
  input  logic               btn_enter,
  output logic [ANGLE_W-1:0] angle_out,
  output logic               coarse,
  output logic               angle_valid,
  input  logic               angle_ready,
  output logic               busy
);

  localparam int W1 = ANGLE_W + 1;
  localparam logic [W1-1:0] MAX_W  = W1'(ANGLE_MAX);
  localparam logic [W1-1:0] MOD_W  = W1'(ANGLE_MAX + 1);
  localparam logic [W1-1:0] STEP_F = W1'(STEP_FINE);
  localparam logic [W1-1:0] STEP_C = W1'(STEP_COARSE);

  typedef enum logic {EDIT = 1'b0, SEND = 1'b1} state_t;

  state_t state_q, state_d;

  // bit order: {enter, mode, dn, up}
  logic [3:0] s1, s2, s3;
  logic [3:0] ev;

  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic               coarse_q, coarse_d;
  logic [W1-1:0]      wide, step, sum;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      state_q  <= EDIT;
      angle_q  <= '0;
      coarse_q <= 1'b0;
    end else begin
      s1       <= {btn_enter, btn_mode, btn_dn, btn_up};
      s2       <= s1;
      s3       <= s2;
      state_q  <= state_d;
      angle_q  <= angle_d;
      coarse_q <= coarse_d;
    end
  end

  assign ev = s2 & ~s3;

  always_comb begin
    state_d  = state_q;
    angle_d  = angle_q;
    coarse_d = coarse_q;
    wide     = {1'b0, angle_q};
    step     = coarse_q ? STEP_C : STEP_F;
    sum      = wide + step;
    case (state_q)
      EDIT: begin
        // step uses the mode in force this cycle, before any toggle lands
        if (ev[0] && !ev[1]) begin
          angle_d = (sum > MAX_W) ? ANGLE_W'(sum - MOD_W) : ANGLE_W'(sum);
        end else if (ev[1] && !ev[0]) begin
          angle_d = (wide < step) ? ANGLE_W'(wide + MOD_W - step) : ANGLE_W'(wide - step);
        end
        if (ev[2]) coarse_d = ~coarse_q;
        if (ev[3]) state_d = SEND;
      end
      SEND: begin
        if (angle_ready) state_d = EDIT;
      end
      default: state_d = EDIT;
    endcase
  end

  assign angle_out   = angle_q;
  assign coarse      = coarse_q;
  assign angle_valid = (state_q == SEND);
  assign busy        = (state_q == SEND);

endmodule

// File: tb/tb_angle_entry.sv
// tb/tb_angle_entry.sv - directed self-checking bench for angle_entry
module tb_angle_entry;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [8:0] angle_out;
  logic       coarse, angle_valid, angle_ready, busy;
  int         checks = 0;
  int         errors = 0;

  localparam logic [3:0] UP = 4'b0001, DN = 4'b0010, MODE = 4'b0100, ENTER = 4'b1000;

  always #5 clk_in = ~clk_in;

  angle_entry dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .btn_up      (btn[0]),
    .btn_dn      (btn[1]),
    .btn_mode    (btn[2]),
    .btn_enter   (btn[3]),
    .angle_out   (angle_out),
    .coarse      (coarse),
    .angle_valid (angle_valid),
    .angle_ready (angle_ready),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at a negedge with the effect settled
  task automatic press(input logic [3:0] m, input int len);
    btn = m;
    repeat (len) @(negedge clk_in);
    btn = 4'b0;
    repeat (4) @(negedge clk_in);
  endtask

  initial begin
    rst = 1'b1;
    btn = 4'b0;
    angle_ready = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset_angle", angle_out, 0);
    check("reset_coarse", coarse, 0);
    check("reset_valid", angle_valid, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk_in);

    // long pulse: one increment, landing on the third edge
    btn = UP;
    @(negedge clk_in); check("lat_edge1", angle_out, 0);
    @(negedge clk_in); check("lat_edge2", angle_out, 0);
    @(negedge clk_in); check("lat_edge3", angle_out, 1);
    repeat (4997) @(negedge clk_in);
    btn = 4'b0;
    repeat (5) @(negedge clk_in);
    check("long_pulse_once", angle_out, 1);
    check("long_pulse_coarse", coarse, 0);

    // coarse sweep from 1: reset to 0 first so the sweep ends at 0
    rst = 1'b1; @(negedge clk_in); rst = 1'b0; @(negedge clk_in);
    press(MODE, 1);
    check("mode_coarse", coarse, 1);
    for (int i = 1; i <= 36; i++) begin
      press(UP, 2);
      check($sformatf("sweep_%0d", i), angle_out, (i * 10) % 360);
    end

    // wrap boundaries
    press(MODE, 1);
    press(DN, 1);
    check("fine_dn_wrap", angle_out, 359);
    repeat (4) press(UP, 1);
    check("fine_up_wrap", angle_out, 3);
    press(MODE, 1);
    press(DN, 1);
    check("coarse_dn_wrap", angle_out, 353);
    press(MODE, 1);
    repeat (2) press(UP, 1);
    press(MODE, 1);
    check("at_355", angle_out, 355);
    press(UP, 1);
    check("coarse_up_wrap", angle_out, 5);

    // submit 45 in fine mode, ignore buttons while stalled
    repeat (4) press(UP, 1);
    press(MODE, 1);
    check("at_45", angle_out, 45);
    check("fine_before_send", coarse, 0);
    press(ENTER, 1);
    for (int i = 0; i < 20; i++) begin
      btn = (i % 4 == 0) ? UP : ((i % 4 == 2) ? MODE : 4'b0);
      @(negedge clk_in);
      check("stall_valid", angle_valid, 1);
      check("stall_angle", angle_out, 45);
      check("stall_coarse", coarse, 0);
    end
    btn = 4'b0;
    repeat (4) @(negedge clk_in);
    check("stall_busy", busy, 1);
    check("stall_angle_end", angle_out, 45);
    angle_ready = 1'b1;
    @(negedge clk_in);
    angle_ready = 1'b0;
    check("xfer_valid_drop", angle_valid, 0);
    check("xfer_angle_kept", angle_out, 45);
    repeat (3) @(negedge clk_in);
    check("no_requeue", angle_valid, 0);
    press(UP, 1);
    check("resume_46", angle_out, 46);

    // simultaneous events
    press(UP | DN, 1);
    check("up_dn_cancel", angle_out, 46);
    press(MODE, 1);
    repeat (4) press(UP, 1);
    press(MODE, 1);
    repeat (3) press(UP, 1);
    check("at_89", angle_out, 89);
    press(UP | ENTER, 1);
    check("up_enter_valid", angle_valid, 1);
    check("up_enter_angle", angle_out, 90);
    angle_ready = 1'b1;
    @(negedge clk_in);
    angle_ready = 1'b0;
    check("xfer2_valid", angle_valid, 0);

    // reset during SEND drops valid and loses an in-flight press
    press(MODE, 1);
    repeat (3) press(UP, 1);
    press(ENTER, 1);
    check("send_120_valid", angle_valid, 1);
    check("send_120_angle", angle_out, 120);
    check("send_120_coarse", coarse, 1);
    btn = UP;
    @(negedge clk_in);
    rst = 1'b1;
    btn = 4'b0;
    @(negedge clk_in);
    rst = 1'b0;
    check("rst_send_valid", angle_valid, 0);
    check("rst_send_angle", angle_out, 0);
    check("rst_send_coarse", coarse, 0);
    repeat (5) @(negedge clk_in);
    check("rst_lost_press", angle_out, 0);
    check("rst_edit_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
